// File: rtl/sudoku_pkg.sv
// Shared Sudoku types and constants: FSM state encoding, board geometry, difficulty masks.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sudoku_pkg;

  // 4x4 board: 16 cells, values 0..3 encode digits 1..4.
  localparam int SDK_ADDR_W = 4;
  localparam int SDK_VAL_W  = 2;

  // Hint masks over rows 1-2. The main controller and the hint loader both use these.
  localparam logic [7:0] MASK_EASY   = 8'h0F;
  localparam logic [7:0] MASK_MEDIUM = 8'h07;
  localparam logic [7:0] MASK_HARD   = 8'h03;

  typedef enum logic [2:0] {
    HL_IDLE    = 3'd0,
    HL_SCAN    = 3'd1,
    HL_CAPTURE = 3'd2,
    HL_WRITE   = 3'd3,
    HL_DONE    = 3'd4
  } hl_state_t;

  // 4-bit counter increment that sticks at 15.
  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/lsb_priority_enc.sv
// Lowest-set-bit priority encoder over a CELLS-wide vector.
// Latency: combinational. Backpressure: none.
// Ports: i_vec (input vector), o_idx (index of lowest set bit, 0 if none), o_any (any bit set).
module lsb_priority_enc #(
  parameter int CELLS = 8,
  parameter int IDX_W = (CELLS > 1) ? $clog2(CELLS) : 1
) (
  input  logic [CELLS-1:0] i_vec,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_any
);

  // Scan from the top down so the lowest set bit is the last one to win.
  always_comb begin
    o_idx = '0;
    o_any = 1'b0;
    for (int i = CELLS - 1; i >= 0; i--) begin
      if (i_vec[i]) begin
        o_idx = IDX_W'(i);
        o_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sudoku_hint_loader.sv
// Loads hint cells selected by a latched mask into the board: per set bit, one ROM read then one fixed-cell write.
// Latency: done at cycle 2+3N after start for N hints with ready high; each cycle of bd_wr_ready low adds one.
// Backpressure: bd_wr_valid/addr/data held stable until bd_wr_ready; at most one ROM read outstanding.
// Ports: clka/restart_n clock and async active-low reset; start/fill_flag run request and mask;
//   sol_rd/sol_addr/sol_data solution ROM (data one cycle after read); bd_wr_* board write handshake;
//   busy/done/hint_count status.
module sudoku_hint_loader
  import sudoku_pkg::*;
#(
  parameter int                CELLS     = 8,
  parameter int                ADDR_W    = SDK_ADDR_W,
  parameter int                VAL_W     = SDK_VAL_W,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clka,
  input  logic              restart_n,
  input  logic              start,
  input  logic [CELLS-1:0]  fill_flag,
  output logic              sol_rd,
  output logic [ADDR_W-1:0] sol_addr,
  input  logic [VAL_W-1:0]  sol_data,
  output logic              bd_wr_valid,
  input  logic              bd_wr_ready,
  output logic [ADDR_W-1:0] bd_wr_addr,
  output logic [VAL_W-1:0]  bd_wr_data,
  output logic              bd_wr_fixed,
  output logic              busy,
  output logic              done,
  output logic [3:0]        hint_count
);

  localparam int IDX_W = (CELLS > 1) ? $clog2(CELLS) : 1;

  hl_state_t          r_state;
  logic [CELLS-1:0]   r_mask;
  logic [IDX_W-1:0]   r_idx;
  logic [ADDR_W-1:0]  r_wr_addr;
  logic [VAL_W-1:0]   r_wr_data;
  logic               r_wr_valid;
  logic               r_busy;
  logic               r_done;
  logic [3:0]         r_hint_count;

  logic [IDX_W-1:0]   w_idx;
  logic               w_any;
  logic               w_sol_rd;
  logic [ADDR_W-1:0]  w_scan_addr;

  lsb_priority_enc #(
    .CELLS (CELLS),
    .IDX_W (IDX_W)
  ) u_enc (
    .i_vec (r_mask),
    .o_idx (w_idx),
    .o_any (w_any)
  );

  // The ROM read has to happen in the SCAN cycle itself, so the strobe and
  // address are decoded from state and the encoder rather than registered.
  // The address is forced to zero outside the strobe so an idle port is quiet.
  assign w_scan_addr = BASE_ADDR + ADDR_W'(w_idx);
  assign w_sol_rd    = (r_state == HL_SCAN) && w_any;
  assign sol_rd      = w_sol_rd;
  assign sol_addr    = w_sol_rd ? w_scan_addr : '0;

  assign bd_wr_valid = r_wr_valid;
  assign bd_wr_fixed = r_wr_valid;
  assign bd_wr_addr  = r_wr_addr;
  assign bd_wr_data  = r_wr_data;
  assign busy        = r_busy;
  assign done        = r_done;
  assign hint_count  = r_hint_count;

  always_ff @(posedge clka or negedge restart_n) begin
    if (!restart_n) begin
      r_state      <= HL_IDLE;
      r_mask       <= '0;
      r_idx        <= '0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      r_wr_valid   <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_hint_count <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        HL_IDLE: begin
          if (start) begin
            r_mask       <= fill_flag;
            r_hint_count <= '0;
            r_busy       <= 1'b1;
            r_state      <= HL_SCAN;
          end
        end
        HL_SCAN: begin
          if (!w_any) begin
            r_done  <= 1'b1;
            r_state <= HL_DONE;
          end else begin
            r_idx   <= w_idx;
            r_state <= HL_CAPTURE;
          end
        end
        HL_CAPTURE: begin
          // ROM data answers the read issued in SCAN.
          r_wr_data  <= sol_data;
          r_wr_addr  <= BASE_ADDR + ADDR_W'(r_idx);
          r_wr_valid <= 1'b1;
          r_state    <= HL_WRITE;
        end
        HL_WRITE: begin
          if (bd_wr_ready) begin
            r_mask       <= r_mask & ~(CELLS'(1) << r_idx);
            r_hint_count <= sat_inc4(r_hint_count);
            r_wr_valid   <= 1'b0;
            r_state      <= HL_SCAN;
          end
        end
        HL_DONE: begin
          // busy covers the done cycle; start here is ignored.
          r_busy  <= 1'b0;
          r_state <= HL_IDLE;
        end
        default: begin
          r_wr_valid <= 1'b0;
          r_busy     <= 1'b0;
          r_state    <= HL_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/sudoku_hint_loader.md
# sudoku_hint_loader

Sequences loading of difficulty-dependent hint cells into the Sudoku board datapath. On a `start` pulse from the main game controller it latches the 8-bit `fill_flag` mask, which covers the cells of rows 1–2. For each set bit, lowest index first, it reads the solution ROM and writes the value into the board as a fixed cell over a valid/ready handshake. It reports `busy`, a one-cycle `done` and the number of hints written, and runs between difficulty selection and the first player input.

## Interface
Parameters:
- `CELLS`, 8: number of mask bits / candidate hint cells.
- `ADDR_W`, 4: board and ROM cell address width (16-cell 4x4 grid).
- `VAL_W`, 2: cell value width (values 0–3 encode digits 1–4).
- `BASE_ADDR`, 0: address of the cell mapped to `fill_flag[0]`.

Ports:
- `clka`  in  1  sole clock; all state updates on rising edge.
- `restart_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request; samples `fill_flag`.
- `fill_flag`  in  CELLS  bit i set = cell `BASE_ADDR+i` receives a hint.
- `sol_rd`  out  1  solution ROM read strobe.
- `sol_addr`  out  ADDR_W  ROM address.
- `sol_data`  in  VAL_W  ROM data, valid the cycle after `sol_rd`.
- `bd_wr_valid`  out  1  board write request.
- `bd_wr_ready`  in  1  board accepts the write this cycle.
- `bd_wr_addr`  out  ADDR_W  board cell address.
- `bd_wr_data`  out  VAL_W  hint value.
- `bd_wr_fixed`  out  1  marks the written cell as locked; equals `bd_wr_valid`.
- `busy`  out  1  high from the cycle after `start` until `done`, inclusive.
- `done`  out  1  one-cycle completion pulse.
- `hint_count`  out  4  hints written in the current or last run; saturates at 15.

## Operation
- States: IDLE, SCAN, CAPTURE, WRITE, DONE.
- IDLE:
  - When `start`=1: latch `fill_flag` into `mask_q`, clear `hint_count`, go to SCAN.
  - `start` in any other state is ignored.
- SCAN: combinational priority encode of `mask_q`, lowest set bit `idx`.
  - `mask_q`=0: go to DONE.
  - Otherwise drive `sol_rd`=1 and `sol_addr`=`BASE_ADDR+idx` for exactly this cycle, register `idx`, go to CAPTURE.
- CAPTURE: register `sol_data` into `bd_wr_data` and `BASE_ADDR+idx` into `bd_wr_addr`, go to WRITE.
- WRITE:
  - `bd_wr_valid`=`bd_wr_fixed`=1.
  - Address and data are held stable until `bd_wr_ready`.
  - On the handshake cycle: clear `mask_q[idx]`, increment `hint_count`, go to SCAN.
- DONE: `done`=1 for one cycle, go to IDLE. `hint_count` and the registered outputs hold until the next accepted `start`.
- Address arithmetic is modulo 2^ADDR_W; wrap past the top of the board is permitted and not flagged.
- Bits of `fill_flag` above CELLS-1 do not exist. Mask changes after latching are ignored.

## Timing
- Reset (`restart_n`=0, asynchronous):
  - state = IDLE; `mask_q`=0.
  - `sol_rd`=0, `sol_addr`=0, `bd_wr_valid`=0, `bd_wr_fixed`=0, `bd_wr_addr`=0, `bd_wr_data`=0, `busy`=0, `done`=0, `hint_count`=0.
- Reset mid-run aborts immediately, and a pending write is dropped. Already-written cells are not rolled back.
- `start` sampled in cycle 0. SCAN is in cycle 1.
- Per hint, minimum 3 cycles (SCAN, CAPTURE, WRITE). Each cycle of `bd_wr_ready`=0 adds one.
- With N hints and `bd_wr_ready` tied high:
  - Hint k (k=0..N-1) handshakes in cycle 3+3k.
  - `done` is in cycle 2+3N.
  - IDLE is in cycle 3+3N.
- `start` coincident with `done` is ignored. `start` is accepted from the first IDLE cycle.
- `sol_rd` never asserts in consecutive cycles; at most one ROM read is outstanding.

## Structure
- Shared package (`sudoku_pkg`):
  - State encoding enum for this block.
  - `VAL_W`/`ADDR_W` constants.
  - Difficulty mask constants EASY=8'h0F, MEDIUM=8'h07, HARD=8'h03, so the main controller and this block agree.
- One sub-module: `lsb_priority_enc`, parameterised by CELLS. Outputs `idx` and `any`. Purely combinational, reusable by the checker.

## Test plan
- Empty mask: `fill_flag`=8'h00, start at cycle 0 -> `done` at cycle 2, no `sol_rd`, no writes, `hint_count`=0.
- Easy mask: `fill_flag`=8'h0F, ready tied 1, ROM returns addr[1:0] -> writes to addr 0,1,2,3 with data 0,1,2,3 at cycles 3,6,9,12; `done` at cycle 14; `hint_count`=4.
- Ordering/gaps: `fill_flag`=8'h81, BASE_ADDR=4 -> writes to addr 4, then addr 11; `hint_count`=2; `done` at cycle 8.
- Backpressure: mask 8'h03, `bd_wr_ready` low for 5 cycles on the first write -> addr/data stable throughout, each write accepted exactly once, `done` at cycle 13.
- Start while busy: second `start` with mask 8'hFF during the run of 8'h03 -> ignored; only 2 writes; `hint_count`=2.
- Reset mid-WRITE: `restart_n` low while `bd_wr_valid`=1 -> all outputs zero in the same cycle; a fresh `start` with 8'h01 afterwards completes normally with `hint_count`=1.
